// File: rtl/program_counter_sequencer.sv
// Nibbler instruction sequencer: owns the 12-bit program counter and produces
// the alternating fetch/execute strobes under run, single-step and halt control.
module program_counter_sequencer #(
  parameter int PC_WIDTH     = 12,
  parameter int RESET_VECTOR = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                halt,
  input  logic                two_byte,
  input  logic                load_pc,
  input  logic [PC_WIDTH-1:0] load_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_en,
  output logic                exec_en,
  output logic                phase,
  output logic                halted,
  output logic [2:0]          state_dbg
);

  // fetch_en and exec_en are one-cycle strobes with no back-pressure: the
  // fetch register and control unit must accept them in the cycle they appear.

  localparam logic [PC_WIDTH-1:0] RST_PC = RESET_VECTOR[PC_WIDTH-1:0];
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_PAUSE  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pend_q, pend_d;
  logic                fetch_en_q, exec_en_q, phase_q, halted_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;

    if (step && state_q != S_HALTED) pend_d = 1'b1;
    if (run) pend_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // IDLE also honours a step pulse arriving in this very cycle
        if (run || step || pend_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        pc_d    = pc_q + PC_ONE;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (load_pc)       pc_d = load_addr;
        else if (two_byte) pc_d = pc_q + PC_ONE;
        if (halt)          state_d = S_HALTED;
        else if (run)      state_d = S_FETCH;
        else               state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (run || pend_q) state_d = S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase

    // Consuming a step wins over a fresh pulse on the same edge.
    if (state_d == S_FETCH && (state_q == S_IDLE || state_q == S_PAUSE))
      pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RST_PC;
      pend_q     <= 1'b0;
      fetch_en_q <= 1'b0;
      exec_en_q  <= 1'b0;
      phase_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      fetch_en_q <= (state_d == S_FETCH);
      exec_en_q  <= (state_d == S_EXEC);
      phase_q    <= (state_d == S_EXEC);
      halted_q   <= (state_d == S_HALTED);
    end
  end

  assign pc        = pc_q;
  assign fetch_en  = fetch_en_q;
  assign exec_en   = exec_en_q;
  assign phase     = phase_q;
  assign halted    = halted_q;
  assign state_dbg = state_q;

endmodule
